// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Brief    : Load/blank and display-output bundle for seg_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_done;

    modport master (
        output load, value, dp_in, blank,
        input  seg, dp, digit_en, frame_done
    );

    modport slave (
        input  load, value, dp_in, blank,
        output seg, dp, digit_en, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Multiplexed 7-segment scanner with tear-free frame-aligned load.
//            Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seg_scan_driver_if.slave    bus
);
    localparam int c_PW = $clog2(CLK_DIV);
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [c_PW-1:0]       r_presc;
    logic [c_IW-1:0]       r_idx;
    logic [4*DIGITS-1:0]   r_pend_val;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_flag;
    logic [4*DIGITS-1:0]   r_disp_val;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_digit_en;

    logic                  w_tick;
    logic                  w_idx_last;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_dpsel;
    logic                  w_suppress;
    logic [6:0]            w_seg_dec;

    assign w_tick     = (r_presc == c_PW'(CLK_DIV - 1));
    assign w_idx_last = (r_idx == c_IW'(DIGITS - 1));
    assign w_wrap     = w_tick && w_idx_last;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        w_nib   = 4'h0;
        w_dpsel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_IW'(k)) begin
                w_nib   = r_disp_val[4*k +: 4];
                w_dpsel = r_disp_dp[k];
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic w_zero_run;

    // Walk from the most significant digit down; a digit is dark while every
    // nibble at or above it is zero. Digit 0 is never part of the walk.
    always_comb begin
        w_zero_run = 1'b1;
        w_suppress = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (r_disp_val[4*k +: 4] == 4'h0);
            if (r_idx == c_IW'(k)) begin
                w_suppress = w_zero_run;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_seg_dec = w_suppress ? 7'b0000000 : hex_to_seg(w_nib);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
            r_seg       <= '0;
            r_dp        <= 1'b0;
            r_digit_en  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end

            // Display only changes at the frame boundary; commit uses the
            // pending contents from before this edge.
            if (w_wrap && r_pend_flag) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end

            if (bus.load) begin
                r_pend_val  <= bus.value;
                r_pend_dp   <= bus.dp_in;
                r_pend_flag <= 1'b1;
            end else if (w_wrap) begin
                r_pend_flag <= 1'b0;
            end

            if (bus.blank) begin
                r_seg      <= '0;
                r_dp       <= 1'b0;
                r_digit_en <= '0;
            end else begin
                r_seg      <= w_seg_dec;
                r_dp       <= w_dpsel;
                r_digit_en <= DIGITS'(1) << r_idx;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_done = w_wrap;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver (DIGITS=4, CLK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;
    localparam int c_DIGITS  = 4;
    localparam int c_CLK_DIV = 4;

    localparam logic [6:0] c_S0 = 7'b1111110;
    localparam logic [6:0] c_S1 = 7'b0110000;
    localparam logic [6:0] c_S2 = 7'b1101101;
    localparam logic [6:0] c_S3 = 7'b1111001;
    localparam logic [6:0] c_SA = 7'b1110111;
    localparam logic [6:0] c_SF = 7'b1000111;

    logic clk;
    logic rst_n;
    int   err_cnt;
    int   chk_cnt;
    int   cyc;
    logic [6:0] r_exp_hi;

    seg_scan_driver_if #(.DIGITS(c_DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS  (c_DIGITS),
        .CLK_DIV (c_CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle; cyc counts edges since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_out(input string tag, input logic [3:0] en, input logic [6:0] sg, input logic d);
        check({tag, ".en"},  32'(bus.digit_en), 32'(en));
        check({tag, ".seg"}, 32'(bus.seg),      32'(sg));
        check({tag, ".dp"},  32'(bus.dp),       32'(d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_out("rst", 4'b0000, 7'b0, 1'b0);
        check("rst.fd", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        cyc       = 0;
        bus.load  = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank = 1'b0;
        @(negedge clk);
        do_reset();

        // First slot after release, then slot advance at cycle 5
        step_to(1);  check_out("first", 4'b0001, c_S0, 1'b0);
        step_to(4);  check("slot0.hold", 32'(bus.digit_en), 32'b0001);
        step_to(5);  check("slot1", 32'(bus.digit_en), 32'b0010);
        step_to(14); check("fd.14", 32'(bus.frame_done), 32'd0);
        step_to(15); check("fd.15", 32'(bus.frame_done), 32'd1);
        step_to(16); check("fd.16", 32'(bus.frame_done), 32'd0);

        // Mid-frame load must not tear the current frame
        step_to(20);
        bus.load = 1'b1; bus.value = 16'h1A2F; bus.dp_in = 4'b0100;
        step();
        bus.load = 1'b0;
        check_out("tear.21", 4'b0010, c_S0, 1'b0);
        step_to(31); check("fd.31", 32'(bus.frame_done), 32'd1);
        step_to(32); check_out("tear.32", 4'b1000, c_S0, 1'b0);
        step_to(33); check_out("ld.d0", 4'b0001, c_SF, 1'b0);
        step_to(37); check_out("ld.d1", 4'b0010, c_S2, 1'b0);
        step_to(41); check_out("ld.d2", 4'b0100, c_SA, 1'b1);
        step_to(45); check_out("ld.d3", 4'b1000, c_S1, 1'b0);

        // Load coincident with commit: 1111 shows first, 2222 one frame later
        bus.dp_in = 4'b0000;
        step_to(40);
        bus.load = 1'b1; bus.value = 16'h1111;
        step();
        bus.load = 1'b0;
        step_to(47);
        check("fd.47", 32'(bus.frame_done), 32'd1);
        bus.load = 1'b1; bus.value = 16'h2222;
        step();
        bus.load = 1'b0;
        step_to(49); check_out("co.1a", 4'b0001, c_S1, 1'b0);
        step_to(61); check_out("co.1b", 4'b1000, c_S1, 1'b0);
        step_to(65); check_out("co.2",  4'b0001, c_S2, 1'b0);

        // Blank for 10 cycles; scanning keeps its timing underneath
        step_to(70);
        bus.blank = 1'b1;
        step_to(71); check_out("blk.71", 4'b0000, 7'b0, 1'b0);
        step_to(80); check_out("blk.80", 4'b0000, 7'b0, 1'b0);
        bus.blank = 1'b0;
        step_to(81); check_out("blk.rel", 4'b0001, c_S2, 1'b0);
        step_to(85); check("blk.next", 32'(bus.digit_en), 32'b0010);

        // Leading zeros
        bus.load = 1'b1; bus.value = 16'h0030;
        step();
        bus.load = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        r_exp_hi = 7'b0000000;
`else
        r_exp_hi = c_S0;
`endif
        step_to(97);  check_out("lz.d0", 4'b0001, c_S0, 1'b0);
        step_to(101); check_out("lz.d1", 4'b0010, c_S3, 1'b0);
        step_to(105); check_out("lz.d2", 4'b0100, r_exp_hi, 1'b0);
        step_to(109); check_out("lz.d3", 4'b1000, r_exp_hi, 1'b0);

        // Reset with pending data set: pending must be discarded
        step_to(110);
        bus.load = 1'b1; bus.value = 16'h4321; bus.dp_in = 4'b1111;
        step();
        bus.load = 1'b0;
        step();
        do_reset();
        step_to(1);  check_out("rr.first", 4'b0001, c_S0, 1'b0);
        step_to(17); check_out("rr.d0", 4'b0001, c_S0, 1'b0);
        step_to(21); check_out("rr.d1", 4'b0010, c_S0, 1'b0);
        step_to(29); check_out("rr.d3", 4'b1000, c_S0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000, clocks per digit slot; legal range >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  capture strobe for value/dp_in.
REQ-006 value  input  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 rightmost.
REQ-007 dp_in  input  DIGITS  decimal-point request per digit, captured with value.
REQ-008 blank  input  1  level; when high, display dark, scanning continues.
REQ-009 seg  output  7  segments, active-high, bit6=a .. bit0=g.
REQ-010 dp  output  1  decimal point for the currently selected digit, active-high.
REQ-011 digit_en  output  DIGITS  one-hot digit select, active-high.
REQ-012 frame_done  output  1  one-cycle pulse at end of each full scan frame.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps; a slot tick occurs on the cycle the count equals CLK_DIV-1.
REQ-014 Digit index advances by one on each slot tick; it wraps from DIGITS-1 to 0.
REQ-015 On the tick wrapping the index to 0: frame_done = 1 for exactly that cycle; any pending capture commits to the display register.
REQ-016 load = 1 writes value/dp_in into the pending register and sets the pending flag on the same edge; a later load before commit overwrites the pending data.
REQ-017 Commit copies the pending contents from before the edge and clears the flag; a load coincident with commit re-sets the flag with the new data, which commits at the following frame.
REQ-018 A commit with the flag clear leaves the display register unchanged; the display never changes mid-frame (no tearing).
REQ-019 Decode is full hex: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 seg, dp, digit_en are registered; they reflect the index/display register with exactly 1 clock of latency.
REQ-021 blank = 1 forces seg = 0, dp = 0 and digit_en = 0 one clock later; prescaler, index, load and commit are unaffected.

Reset
REQ-022 rst_n = 0 at an edge clears prescaler, index, display register, pending register and pending flag; seg = 0, dp = 0, digit_en = 0, frame_done = 0.
REQ-023 Reset asserted mid-frame or mid-load discards pending data; no commit occurs on that edge.
REQ-024 On the first edge after release, outputs show digit 0 of the cleared register: digit_en = 0...01, seg = 1111110, dp = 0.

Configuration
REQ-025 Macro SEG_LZ_BLANK_EN defined: each digit k > 0 whose nibble and all higher nibbles are zero has seg = 0, while its digit_en and dp stay normal; digit 0 is never suppressed.
REQ-026 Macro SEG_LZ_BLANK_EN undefined: every digit is decoded per REQ-019, zeros included.

Verification
REQ-027 Reset/first slot: DIGITS=4, CLK_DIV=4, release rst_n -> next cycle digit_en=0001, seg=1111110; digit_en=0010 five cycles after release; frame_done pulses every 16 cycles.
REQ-028 Tear-free load: load value=16'h1A2F mid-frame -> display unchanged until frame_done; following slots show F=1000111, 2=1101101, A=1110111, 1=0110000.
REQ-029 Coincident load and commit: pending 16'h1111, load 16'h2222 on the wrap tick -> frame shows 1s, next frame shows 2s.
REQ-030 Blank: blank=1 for 10 cycles mid-frame -> seg=0, digit_en=0000 from one cycle later; index on release matches unblanked timing.
REQ-031 Leading zeros: value=16'h0030 -> with SEG_LZ_BLANK_EN digit 3 seg=0000000, digits 1 and 0 show 1111001 and 1111110; without the macro digit 3 shows 1111110.
REQ-032 Reset mid-operation: assert rst_n=0 with pending flag set -> after release, display shows 0000 and the pending data never commits.
